crossbar_unshift: RTL and testbench
===================================

# crossbar_unshift

Inverse of the lane-rotation crossbar on the PE-array output side: accepts 8 rotated lanes per beat and restores logical lane order before results are written to the output buffer. It tracks the rotation amount with an internal timestamp counter that advances once per accepted beat, so the rotation amount is not carried on the interface. It sits between the PE-array result lanes and the output write path. A 2-entry output queue with valid/ready absorbs backpressure from that write path.

## Interface
- DATA_WIDTH, 32, width of one lane
- CYCLE_LEN, 8, rotation period (M / k); legal range 1..8; timestamp wraps after CYCLE_LEN beats
- clk  input  1  clock; all state changes on the rising edge
- rst_n  input  1  asynchronous, active-low reset
- clk_en  input  1  clock enable; when low, all state is frozen
- in_valid  input  1  upstream beat present
- in_ready  output  1  block can accept a beat
- in_last  input  1  final beat of a tile; qualified by in_valid
- in0..in7  input  DATA_WIDTH each  rotated lanes
- out_valid  output  1  head entry valid
- out_ready  input  1  downstream accepts the head entry
- out_last  output  1  in_last carried with the head entry
- out0..out7  output  DATA_WIDTH each  de-rotated lanes of the head entry
- timestamp  output  3  current rotation amount, applied to the next accepted beat
- err_misalign  output  1  sticky; set when in_last arrives with timestamp != CYCLE_LEN-1

## Operation
- Accept (push) = clk_en & in_valid & in_ready.
- Pop = clk_en & out_valid & out_ready.
- Un-rotation uses the timestamp value before that cycle's update: out lane (i + t) mod 8 = in lane i, for t = timestamp and i = 0..7.
- t = 0 is pass-through.
- The rotation is a combinational function of the inputs and is written directly into the queue. There is no extra pipeline stage.
- Queue: 2 entries, each holding 8 lanes plus a last bit. Kept in FIFO order with a count register of 0..2.
- in_ready = clk_en & (count < 2). It is driven from registered state only and never depends on out_ready.
- out_valid = (count != 0).
- out0..out7 and out_last always show the head entry.
- Count update:
  - push only: +1
  - pop only: -1
  - push and pop together (possible only at count 1): unchanged; the head advances and the new entry becomes the head.
- Timestamp update on accept:
  - If in_last, or timestamp == CYCLE_LEN-1: timestamp <= 0.
  - Otherwise: timestamp <= timestamp + 1.
  - No update without an accept.
- err_misalign:
  - Set on accept with in_last=1 and timestamp != CYCLE_LEN-1.
  - Cleared only by reset.
  - The beat is still enqueued normally, and timestamp still resets to 0.
- clk_en = 0:
  - No push and no pop; in_ready = 0.
  - out_valid and the head data hold their values.
  - The counter and the error flag hold their values.
- CYCLE_LEN = 1: timestamp stays 0 permanently; the block is pure pass-through with queueing, and err_misalign can never be set.

## Timing
- Reset values (asynchronous, on rst_n low):
  - count = 0, so out_valid = 0 and in_ready = 0 while clk_en = 0.
  - timestamp = 0, err_misalign = 0.
  - out0..out7 = 0, out_last = 0.
- Latency: a beat accepted at rising edge N is visible on out0..out7 with out_valid = 1 in the cycle after edge N.
- Throughput:
  - One beat per cycle while out_ready stays high.
  - With out_ready low, exactly 2 beats are accepted, then in_ready drops.
  - in_ready rises in the cycle after the first pop.
- Holding rules:
  - Output data and out_last must stay stable while out_valid = 1 and out_ready = 0.
  - Upstream must hold in* stable while in_valid = 1 and in_ready = 0.
- Reset asserted mid-tile: queue contents are discarded, timestamp returns to 0, and outputs are 0 immediately (no clock edge required).

## Test plan
- Rotation sweep:
  - Stimulus: CYCLE_LEN = 8, out_ready = 1; 8 beats with lane i = 16*beat + i.
  - Response: on beat t, out lane (i+t) mod 8 = 16*t + i.
  - Response: timestamp reads 0, 1, ..., 7, 0; out_last = 0 throughout; err_misalign = 0.
- Backpressure:
  - Stimulus: out_ready = 0; offer 3 beats.
  - Response: first 2 are accepted and in_ready = 0 in the cycle after the second accept.
  - Stimulus: raise out_ready.
  - Response: beats emerge in order, the third is accepted in the cycle after the first pop, and output data is unchanged while stalled.
- Early last:
  - Stimulus: CYCLE_LEN = 8; in_last on the 5th beat (timestamp = 4).
  - Response: err_misalign = 1 after that edge; out_last = 1 on that entry.
  - Response: the next beat uses timestamp 0 (pass-through); err_misalign stays 1.
- Clock enable:
  - Stimulus: drop clk_en for 3 cycles with in_valid = 1 and out_ready = 1.
  - Response: in_ready = 0; no timestamp change; no pop; head entry held; streaming resumes unchanged when clk_en = 1.
- Reset mid-tile:
  - Stimulus: after 3 accepted beats with queue count 2, assert rst_n = 0 between edges.
  - Response: out_valid = 0, timestamp = 0 and out0..out7 = 0 immediately.
  - Response: the first beat after release passes through unrotated.
- Short cycle:
  - Stimulus: CYCLE_LEN = 3; 7 beats, no in_last.
  - Response: timestamp sequence 0, 1, 2, 0, 1, 2, 0; rotation of each beat matches its timestamp.

Source files
------------

// File: rtl/crossbar_unshift.sv
// Undoes the PE-array lane rotation using a beat-counting timestamp and
// buffers de-rotated beats in a 2-entry FIFO toward the output write path.
module crossbar_unshift #(
  parameter int DATA_WIDTH = 32,
  parameter int CYCLE_LEN  = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clk_en,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic                  in_last,
  input  logic [DATA_WIDTH-1:0] in0,
  input  logic [DATA_WIDTH-1:0] in1,
  input  logic [DATA_WIDTH-1:0] in2,
  input  logic [DATA_WIDTH-1:0] in3,
  input  logic [DATA_WIDTH-1:0] in4,
  input  logic [DATA_WIDTH-1:0] in5,
  input  logic [DATA_WIDTH-1:0] in6,
  input  logic [DATA_WIDTH-1:0] in7,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  out_last,
  output logic [DATA_WIDTH-1:0] out0,
  output logic [DATA_WIDTH-1:0] out1,
  output logic [DATA_WIDTH-1:0] out2,
  output logic [DATA_WIDTH-1:0] out3,
  output logic [DATA_WIDTH-1:0] out4,
  output logic [DATA_WIDTH-1:0] out5,
  output logic [DATA_WIDTH-1:0] out6,
  output logic [DATA_WIDTH-1:0] out7,
  output logic [2:0]            timestamp,
  output logic                  err_misalign
);

  localparam int         LANES   = 8;
  localparam logic [2:0] TS_LAST = 3'(CYCLE_LEN - 1);

  typedef logic [LANES-1:0][DATA_WIDTH-1:0] lanes_t;

  // Output lane j receives input lane (j - t) mod 8.
  function automatic lanes_t unrotate(input lanes_t x, input logic [2:0] t);
    lanes_t r;
    for (int j = 0; j < LANES; j++) r[j] = x[3'(j) - t];
    return r;
  endfunction

  lanes_t     in_lanes;
  lanes_t     rot_p0;
  lanes_t     head_p1;
  lanes_t     tail_p1;
  logic       head_last_p1;
  logic       tail_last_p1;
  logic [1:0] count;
  logic       push;
  logic       pop;

  assign in_lanes  = {in7, in6, in5, in4, in3, in2, in1, in0};
  assign rot_p0    = unrotate(in_lanes, timestamp);

  assign in_ready  = clk_en & (count != 2'd2);
  assign out_valid = (count != 2'd0);
  assign push      = clk_en & in_valid & in_ready;
  assign pop       = clk_en & out_valid & out_ready;

  // ---- stage p0 -> p1: de-rotated beat enters the queue ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count        <= 2'd0;
      head_p1      <= '0;
      tail_p1      <= '0;
      head_last_p1 <= 1'b0;
      tail_last_p1 <= 1'b0;
    end else begin
      case ({push, pop})
        2'b10: begin
          if (count == 2'd0) begin
            head_p1      <= rot_p0;
            head_last_p1 <= in_last;
          end else begin
            tail_p1      <= rot_p0;
            tail_last_p1 <= in_last;
          end
          count <= count + 2'd1;
        end
        2'b01: begin
          head_p1      <= tail_p1;
          head_last_p1 <= tail_last_p1;
          count        <= count - 2'd1;
        end
        // Simultaneous push/pop only happens at count 1: new beat becomes head.
        2'b11: begin
          head_p1      <= rot_p0;
          head_last_p1 <= in_last;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      timestamp    <= 3'd0;
      err_misalign <= 1'b0;
    end else if (push) begin
      if (in_last || (timestamp == TS_LAST)) timestamp <= 3'd0;
      else                                   timestamp <= timestamp + 3'd1;
      if (in_last && (timestamp != TS_LAST)) err_misalign <= 1'b1;
    end
  end

  assign out_last = head_last_p1;
  assign out0     = head_p1[0];
  assign out1     = head_p1[1];
  assign out2     = head_p1[2];
  assign out3     = head_p1[3];
  assign out4     = head_p1[4];
  assign out5     = head_p1[5];
  assign out6     = head_p1[6];
  assign out7     = head_p1[7];

endmodule

// File: tb/tb_crossbar_unshift.sv
// Scoreboard bench for crossbar_unshift: one instance with an 8-beat rotation
// period and one with a 3-beat period, sharing clock, reset and lane data.
module tb_crossbar_unshift;
  localparam int DW = 32;

  typedef logic [7:0][DW-1:0] lanes_t;
  typedef struct packed {
    logic   last;
    lanes_t d;
  } ent_t;

  logic          clk = 1'b0;
  logic          rst_n, clk_en, in_valid, in_valid3, in_last, out_ready, out_ready3;
  logic [DW-1:0] din [8];
  wire  [DW-1:0] dout [8];
  wire  [DW-1:0] dout3 [8];
  wire           in_ready, in_ready3, out_valid, out_valid3, out_last, out_last3, err, err3;
  wire  [2:0]    ts, ts3;

  ent_t       q[$];
  ent_t       q3[$];
  logic [2:0] m_ts, m3_ts;
  logic       m_err, m3_err;
  int         checks = 0;
  int         errors = 0;

  always #5 clk = ~clk;

  crossbar_unshift #(.DATA_WIDTH(DW), .CYCLE_LEN(8)) dut (
    .clk(clk), .rst_n(rst_n), .clk_en(clk_en),
    .in_valid(in_valid), .in_ready(in_ready), .in_last(in_last),
    .in0(din[0]), .in1(din[1]), .in2(din[2]), .in3(din[3]),
    .in4(din[4]), .in5(din[5]), .in6(din[6]), .in7(din[7]),
    .out_valid(out_valid), .out_ready(out_ready), .out_last(out_last),
    .out0(dout[0]), .out1(dout[1]), .out2(dout[2]), .out3(dout[3]),
    .out4(dout[4]), .out5(dout[5]), .out6(dout[6]), .out7(dout[7]),
    .timestamp(ts), .err_misalign(err)
  );

  crossbar_unshift #(.DATA_WIDTH(DW), .CYCLE_LEN(3)) dut3 (
    .clk(clk), .rst_n(rst_n), .clk_en(clk_en),
    .in_valid(in_valid3), .in_ready(in_ready3), .in_last(1'b0),
    .in0(din[0]), .in1(din[1]), .in2(din[2]), .in3(din[3]),
    .in4(din[4]), .in5(din[5]), .in6(din[6]), .in7(din[7]),
    .out_valid(out_valid3), .out_ready(out_ready3), .out_last(out_last3),
    .out0(dout3[0]), .out1(dout3[1]), .out2(dout3[2]), .out3(dout3[3]),
    .out4(dout3[4]), .out5(dout3[5]), .out6(dout3[6]), .out7(dout3[7]),
    .timestamp(ts3), .err_misalign(err3)
  );

  task automatic check_eq(input string tag, input logic [263:0] act, input logic [263:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  function automatic lanes_t mk(input int base);
    lanes_t r;
    for (int i = 0; i < 8; i++) r[i] = DW'(base + i);
    return r;
  endfunction

  // Reference rotation: input lane i lands on output lane (i + t) mod 8.
  function automatic lanes_t rot_model(input lanes_t x, input int t);
    lanes_t r;
    for (int i = 0; i < 8; i++) r[(i + t) % 8] = x[i];
    return r;
  endfunction

  function automatic logic [2:0] next_ts(input logic [2:0] t, input logic last, input int cl);
    return (last || (int'(t) == cl - 1)) ? 3'd0 : t + 3'd1;
  endfunction

  function automatic lanes_t pack_in();
    lanes_t r;
    for (int i = 0; i < 8; i++) r[i] = din[i];
    return r;
  endfunction

  function automatic lanes_t pack_out();
    lanes_t r;
    for (int i = 0; i < 8; i++) r[i] = dout[i];
    return r;
  endfunction

  function automatic lanes_t pack_out3();
    lanes_t r;
    for (int i = 0; i < 8; i++) r[i] = dout3[i];
    return r;
  endfunction

  // Scoreboard: push on accept, pop and compare on output handshake.
  always @(negedge clk or negedge rst_n) begin : mon
    ent_t e;
    if (!rst_n) begin
      q.delete(); q3.delete();
      m_ts = 3'd0; m3_ts = 3'd0; m_err = 1'b0; m3_err = 1'b0;
    end else begin
      check_eq("err_misalign", err, m_err);
      check_eq("err_misalign3", err3, m3_err);
      if (clk_en && in_valid && in_ready) begin
        check_eq("timestamp", ts, m_ts);
        q.push_back({in_last, rot_model(pack_in(), int'(m_ts))});
        if (in_last && m_ts != 3'd7) m_err = 1'b1;
        m_ts = next_ts(m_ts, in_last, 8);
      end
      if (clk_en && out_valid && out_ready) begin
        if (q.size() == 0) check_eq("pop_empty", q.size(), 1);
        else begin
          e = q.pop_front();
          check_eq("out_data", pack_out(), e.d);
          check_eq("out_last", out_last, e.last);
        end
      end
      if (clk_en && in_valid3 && in_ready3) begin
        check_eq("timestamp3", ts3, m3_ts);
        q3.push_back({1'b0, rot_model(pack_in(), int'(m3_ts))});
        m3_ts = next_ts(m3_ts, 1'b0, 3);
      end
      if (clk_en && out_valid3 && out_ready3) begin
        if (q3.size() == 0) check_eq("pop_empty3", q3.size(), 1);
        else begin
          e = q3.pop_front();
          check_eq("out_data3", pack_out3(), e.d);
          check_eq("out_last3", out_last3, e.last);
        end
      end
    end
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic send(input int base, input logic last, input bit sel3);
    int n;
    for (int i = 0; i < 8; i++) din[i] = DW'(base + i);
    in_last = sel3 ? 1'b0 : last;
    if (sel3) in_valid3 = 1'b1;
    else      in_valid  = 1'b1;
    n = 0;
    forever begin
      @(negedge clk);
      if (sel3 ? in_ready3 : in_ready) break;
      n++;
      if (n > 20) begin
        check_eq("send_timeout", n, 20);
        break;
      end
    end
    @(posedge clk); #1;
    in_valid = 1'b0; in_valid3 = 1'b0; in_last = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b1; clk_en = 1'b0; in_valid = 1'b0; in_valid3 = 1'b0; in_last = 1'b0;
    out_ready = 1'b0; out_ready3 = 1'b1;
    for (int i = 0; i < 8; i++) din[i] = '0;
    #1 rst_n = 1'b0;
    #1;
    check_eq("rst_out_valid", out_valid, 0);
    check_eq("rst_in_ready", in_ready, 0);
    check_eq("rst_timestamp", ts, 0);
    check_eq("rst_err", err, 0);
    check_eq("rst_data", pack_out(), 0);
    check_eq("rst_last", out_last, 0);
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    step();
    clk_en = 1'b1; out_ready = 1'b1;

    // Rotation sweep
    for (int b = 0; b < 8; b++) send(16 * b, 1'b0, 1'b0);
    check_eq("sweep_wrap_ts", ts, 0);
    repeat (3) step();

    // Backpressure
    out_ready = 1'b0;
    send(200, 1'b0, 1'b0);
    send(300, 1'b0, 1'b0);
    check_eq("bp_full", in_ready, 0);
    for (int i = 0; i < 8; i++) din[i] = DW'(400 + i);
    in_valid = 1'b1;
    repeat (3) begin
      step();
      check_eq("bp_stall_ready", in_ready, 0);
      check_eq("bp_hold", pack_out(), rot_model(mk(200), 0));
    end
    out_ready = 1'b1;
    step();
    check_eq("bp_ready_after_pop", in_ready, 1);
    step();
    in_valid = 1'b0;
    repeat (3) step();
    check_eq("bp_ts", ts, 3);

    // Legal last at timestamp 7, then early last at timestamp 4
    for (int b = 0; b < 4; b++) send(500 + 16 * b, 1'b0, 1'b0);
    send(600, 1'b1, 1'b0);
    check_eq("legal_last_err", err, 0);
    check_eq("legal_last_ts", ts, 0);
    for (int b = 0; b < 4; b++) send(700 + 16 * b, 1'b0, 1'b0);
    send(800, 1'b1, 1'b0);
    check_eq("early_last_err", err, 1);
    check_eq("early_last_ts", ts, 0);
    send(900, 1'b0, 1'b0);
    check_eq("err_sticky", err, 1);
    repeat (3) step();

    // Clock enable freeze
    out_ready = 1'b0;
    send(1000, 1'b0, 1'b0);
    out_ready = 1'b1; clk_en = 1'b0;
    for (int i = 0; i < 8; i++) din[i] = DW'(1100 + i);
    in_valid = 1'b1;
    repeat (3) begin
      step();
      check_eq("ce_in_ready", in_ready, 0);
      check_eq("ce_ts", ts, 2);
      check_eq("ce_out_valid", out_valid, 1);
      check_eq("ce_head", pack_out(), rot_model(mk(1000), 1));
    end
    clk_en = 1'b1;
    step();
    in_valid = 1'b0;
    repeat (3) step();

    // Reset mid-tile with two entries queued
    send(1200, 1'b0, 1'b0);
    send(1300, 1'b0, 1'b0);
    out_ready = 1'b0;
    send(1400, 1'b0, 1'b0);
    check_eq("pre_reset_full", in_ready, 0);
    #1 rst_n = 1'b0;
    #1;
    check_eq("midrst_out_valid", out_valid, 0);
    check_eq("midrst_ts", ts, 0);
    check_eq("midrst_data", pack_out(), 0);
    check_eq("midrst_err", err, 0);
    #1 rst_n = 1'b1;
    out_ready = 1'b1;
    send(1500, 1'b0, 1'b0);
    check_eq("post_reset_passthru", pack_out(), mk(1500));
    repeat (3) step();

    // Short rotation period
    for (int b = 0; b < 7; b++) send(2000 + 16 * b, 1'b0, 1'b1);
    check_eq("short_ts_final", ts3, 1);
    check_eq("short_err", err3, 0);
    repeat (4) step();

    check_eq("drain", q.size(), 0);
    check_eq("drain3", q3.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
